// File: rtl/ddk_uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, tag nibble,
// parameter limits and the tag-byte builder.
package ddk_uart_arb_pkg;

    typedef enum logic [0:0] {
        UART_ARB_IDLE = 1'b0,
        UART_ARB_SEND = 1'b1
    } uart_arb_state_e;

    localparam logic [3:0] UART_ARB_TAG             = 4'hA;
    localparam int         UART_ARB_MAX_REQ         = 8;
    localparam int         UART_ARB_MAX_FRAME_BYTES = 8;

    function automatic logic [7:0] uart_arb_tag_byte(input logic [2:0] idx);
        return {UART_ARB_TAG, 1'b0, idx};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin pick: the first set request bit found
// searching upward from (last+1) mod N_REQ wins.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt
);

    logic             found_s;
    logic [IDX_W-1:0] idx_s;

    // Rotating priority search; found_s masks every candidate after the winner.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s      = IDX_W'((int'(last) + i) % N_REQ);
            gnt[idx_s] = req[idx_s] & ~found_s;
            found_s    = found_s | req[idx_s];
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-atomic round-robin arbiter serialising whole frames into one uart_tx.
// Define UART_TX_ARB_TAG_EN to prefix each frame with a requester tag byte.
module uart_tx_arb
    import ddk_uart_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int FRAME_BYTES = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ*FRAME_BYTES*8-1:0] frame_i,
    output logic [N_REQ-1:0]               gnt_o,
    output logic [7:0]                     tx_data_o,
    output logic                           tx_en_o,
    input  logic                           tx_rdy_i,
    output logic                           busy_o
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FRAME_W = FRAME_BYTES * 8;
`ifdef UART_TX_ARB_TAG_EN
    localparam int TOTAL_BYTES = FRAME_BYTES + 1;
`else
    localparam int TOTAL_BYTES = FRAME_BYTES;
`endif
    localparam int SHIFT_W = TOTAL_BYTES * 8;
    localparam int CNT_W   = $clog2(TOTAL_BYTES + 1);

    uart_arb_state_e  state_r, state_s;
    logic [IDX_W-1:0] last_r, last_s, pick_idx_s;
    logic [N_REQ-1:0] pick_s, gnt_r, gnt_s;
    logic [FRAME_W-1:0] frame_sel_s;
    logic [SHIFT_W-1:0] shift_r, shift_s, load_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             tx_en_r, tx_en_s;
    logic             busy_r;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req  (req_i),
        .last (last_r),
        .gnt  (pick_s)
    );

    // Mux the winner's frame slice and encode its index from the one-hot pick.
    always_comb begin
        frame_sel_s = '0;
        pick_idx_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            frame_sel_s = frame_sel_s | ({FRAME_W{pick_s[k]}} & frame_i[k*FRAME_W +: FRAME_W]);
            pick_idx_s  = pick_idx_s | ({IDX_W{pick_s[k]}} & IDX_W'(k));
        end
`ifdef UART_TX_ARB_TAG_EN
        load_s = {uart_arb_tag_byte(3'(pick_idx_s)), frame_sel_s};
`else
        load_s = frame_sel_s;
`endif
    end

    // Next-state and datapath; a byte goes out only when the previous strobe is low.
    always_comb begin
        state_s   = state_r;
        last_s    = last_r;
        gnt_s     = '0;
        shift_s   = shift_r;
        cnt_s     = cnt_r;
        tx_data_s = tx_data_r;
        tx_en_s   = 1'b0;
        case (state_r)
            UART_ARB_IDLE: begin
                if (|req_i) begin
                    gnt_s   = pick_s;
                    last_s  = pick_idx_s;
                    shift_s = load_s;
                    cnt_s   = CNT_W'(TOTAL_BYTES);
                    state_s = UART_ARB_SEND;
                end else begin
                    state_s = UART_ARB_IDLE;
                end
            end
            UART_ARB_SEND: begin
                if (!tx_en_r && tx_rdy_i) begin
                    tx_data_s = shift_r[SHIFT_W-1 -: 8];
                    tx_en_s   = 1'b1;
                    shift_s   = shift_r << 4'd8;
                    cnt_s     = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_s = UART_ARB_IDLE;
                    end else begin
                        state_s = UART_ARB_SEND;
                    end
                end else begin
                    state_s = UART_ARB_SEND;
                end
            end
            default: begin
                state_s = UART_ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partially sent frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= UART_ARB_IDLE;
            last_r    <= IDX_W'(N_REQ - 1);
            gnt_r     <= '0;
            shift_r   <= '0;
            cnt_r     <= '0;
            tx_data_r <= 8'h00;
            tx_en_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            last_r    <= last_s;
            gnt_r     <= gnt_s;
            shift_r   <= shift_s;
            cnt_r     <= cnt_s;
            tx_data_r <= tx_data_s;
            tx_en_r   <= tx_en_s;
            busy_r    <= (state_s == UART_ARB_SEND);
        end
    end

    assign gnt_o     = gnt_r;
    assign tx_data_o = tx_data_r;
    assign tx_en_o   = tx_en_r;
    assign busy_o    = busy_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a default 2x3-byte instance and a 4x1-byte
// instance. Expected streams include the tag byte when UART_TX_ARB_TAG_EN is set.
module tb_uart_tx_arb;

`ifdef UART_TX_ARB_TAG_EN
    localparam int TAG = 1;
`else
    localparam int TAG = 0;
`endif
    localparam int TBA = 3 + TAG;
    localparam int TBB = 1 + TAG;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [1:0]  req_a;
    logic [47:0] frame_a;
    logic [1:0]  gnt_a;
    logic [7:0]  data_a;
    logic        en_a, busy_a;
    logic [3:0]  req_b;
    logic [31:0] frame_b;
    logic [3:0]  gnt_b;
    logic [7:0]  data_b;
    logic        en_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arb dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .frame_i(frame_a),
        .gnt_o(gnt_a), .tx_data_o(data_a), .tx_en_o(en_a), .tx_rdy_i(rdy), .busy_o(busy_a)
    );

    uart_tx_arb #(.N_REQ(4), .FRAME_BYTES(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .frame_i(frame_b),
        .gnt_o(gnt_b), .tx_data_o(data_b), .tx_en_o(en_b), .tx_rdy_i(rdy), .busy_o(busy_b)
    );

    typedef struct {
        logic [1:0]  req;
        logic [23:0] f0;
        logic [1:0]  gnt;
        logic        en;
        logic [7:0]  data;
        logic        busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 2'b00;
        req_b = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [7:0]  exp_bytes[$];
        logic [7:0]  bq[$];
        logic [3:0]  gq[$];
        int          cq[$];
        int          n;
        int          cnt;
        int          viol;
        logic        prev_en;
        logic [7:0]  e;

        rdy     = 1'b1;
        frame_a = 48'h0;
        frame_b = 32'h0;
        do_reset();

        // Reset values, sampled while reset is still held.
        rst_n = 1'b0;
        #1;
        check("rst_gnt_a", gnt_a, 2'b00);
        check("rst_en_a", en_a, 1'b0);
        check("rst_data_a", data_a, 8'h00);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_busy_b", busy_b, 1'b0);
        do_reset();

        // Single frame: cycle-by-cycle table.
`ifdef UART_TX_ARB_TAG_EN
        exp_bytes.push_back(8'hA0);
`endif
        exp_bytes.push_back(8'h01);
        exp_bytes.push_back(8'h3C);
        exp_bytes.push_back(8'hA5);
        n = exp_bytes.size();
        vecs.push_back('{req: 2'b01, f0: 24'h013CA5, gnt: 2'b01, en: 1'b0, data: 8'h00, busy: 1'b1});
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{req: 2'b00, f0: 24'h013CA5, gnt: 2'b00, en: 1'b1, data: exp_bytes[i], busy: (i != n - 1)});
            vecs.push_back('{req: 2'b00, f0: 24'h013CA5, gnt: 2'b00, en: 1'b0, data: exp_bytes[i], busy: (i != n - 1)});
        end
        for (int i = 0; i < vecs.size(); i++) begin
            req_a   = vecs[i].req;
            frame_a = {24'h0, vecs[i].f0};
            step();
            check($sformatf("tbl%0d_gnt", i), gnt_a, vecs[i].gnt);
            check($sformatf("tbl%0d_en", i), en_a, vecs[i].en);
            check($sformatf("tbl%0d_data", i), data_a, vecs[i].data);
            check($sformatf("tbl%0d_busy", i), busy_a, vecs[i].busy);
        end

        // Contention: both requesters held high.
        do_reset();
        frame_a = {24'h222222, 24'h111111};
        req_a   = 2'b11;
        viol    = 0;
        prev_en = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (gnt_a != 2'b00) gq.push_back({2'b00, gnt_a});
            if (en_a) bq.push_back(data_a);
            if (en_a && prev_en) viol++;
            prev_en = en_a;
        end
        req_a = 2'b00;
        check("cont_ngnt", gq.size() >= 4, 1'b1);
        check("cont_nbytes", bq.size() >= 4 * TBA, 1'b1);
        check("cont_b2b_en", viol, 0);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("cont_gnt%0d", i), gq[i], (i % 2 == 0) ? 4'b0001 : 4'b0010);
        for (int j = 0; j < 4 * TBA && j < bq.size(); j++) begin
            if (TAG == 1 && (j % TBA) == 0) e = 8'hA0 | 8'((j / TBA) % 2);
            else e = ((j / TBA) % 2 == 1) ? 8'h22 : 8'h11;
            check($sformatf("cont_byte%0d", j), bq[j], e);
        end

        // Stall after the first byte.
        do_reset();
        frame_a = {24'h0, 24'h013CA5};
        req_a   = 2'b01;
        step();
        req_a = 2'b00;
        step();
        check("stall_first_en", en_a, 1'b1);
        check("stall_first_data", data_a, exp_bytes[0]);
        rdy = 1'b0;
        cnt = 0;
        repeat (50) begin
            step();
            if (en_a) cnt++;
        end
        check("stall_no_en", cnt, 0);
        check("stall_busy", busy_a, 1'b1);
        rdy = 1'b1;
        bq.delete();
        for (int c = 0; c < 20; c++) begin
            step();
            if (en_a) bq.push_back(data_a);
        end
        check("stall_rest_count", bq.size(), n - 1);
        for (int j = 1; j < n && j - 1 < bq.size(); j++)
            check($sformatf("stall_byte%0d", j), bq[j-1], exp_bytes[j]);
        check("stall_busy_end", busy_a, 1'b0);

        // Reset in the middle of a frame.
        do_reset();
        frame_a = {24'h0, 24'h013CA5};
        req_a   = 2'b01;
        step();
        req_a = 2'b00;
        step();
        check("mrst_byte1", en_a, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_gnt", gnt_a, 2'b00);
        check("mrst_en", en_a, 1'b0);
        check("mrst_data", data_a, 8'h00);
        check("mrst_busy", busy_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            step();
            if (en_a || busy_a) cnt++;
        end
        check("mrst_quiet", cnt, 0);
        req_a = 2'b11;
        step();
        check("mrst_next_gnt", gnt_a, 2'b01);
        req_a = 2'b00;

        // N_REQ=4, FRAME_BYTES=1 with requests 1010 held.
        do_reset();
        frame_b = {8'h43, 8'h32, 8'h21, 8'h10};
        req_b   = 4'b1010;
        gq.delete();
        bq.delete();
        for (int c = 0; c < 30; c++) begin
            step();
            if (gnt_b != 4'b0000) begin
                gq.push_back(gnt_b);
                cq.push_back(0);
            end
            if (en_b) begin
                bq.push_back(data_b);
                if (cq.size() > 0) cq[cq.size()-1]++;
            end
        end
        req_b = 4'b0000;
        check("b_ngnt", gq.size() >= 3, 1'b1);
        for (int i = 0; i < 3 && i < gq.size(); i++) begin
            check($sformatf("b_gnt%0d", i), gq[i], (i % 2 == 0) ? 4'b0010 : 4'b1000);
            check($sformatf("b_cnt%0d", i), cq[i], TBB);
        end
        for (int j = 0; j < 3 * TBB && j < bq.size(); j++) begin
            if (TAG == 1 && (j % TBB) == 0) e = ((j / TBB) % 2 == 0) ? 8'hA1 : 8'hA3;
            else e = ((j / TBB) % 2 == 0) ? 8'h21 : 8'h43;
            check($sformatf("b_byte%0d", j), bq[j], e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
